// File: rtl/mult_div_seq.sv
// Iterative multiply/divide unit owning the HI/LO registers: 32-step shift-add
// multiply and restoring divide, plus the registered MFHI/MFLO read port.
module mult_div_seq #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] in_1,
   input  logic [XLEN-1:0] in_2,
   input  logic            rd_en,
   input  logic            rd_sel,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_valid,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam logic [2:0] OP_MTHI  = 3'd0;
   localparam logic [2:0] OP_MTLO  = 3'd1;
   localparam logic [2:0] OP_MULT  = 3'd2;
   localparam logic [2:0] OP_MULTU = 3'd3;
   localparam logic [2:0] OP_DIV   = 3'd4;
   localparam logic [2:0] OP_DIVU  = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t              state_reg, state_next;
   logic [5:0]          cnt_reg;
   logic [2*XLEN-1:0]   acc_reg, acc_next;
   logic [XLEN-1:0]     opnd_reg;
   logic [XLEN-1:0]     raw_a_reg;
   logic                is_div_reg;
   logic                neg_res_reg;
   logic                neg_rem_reg;
   logic                div0_reg;
   logic [XLEN-1:0]     hi_reg, lo_reg;
   logic [XLEN-1:0]     rd_data_reg;
   logic                rd_valid_reg;

   // Request decode, only meaningful while idle
   logic            idle;
   logic            op_mul, op_div, op_signed;
   logic            launch, wr_hi, wr_lo;
   logic            sign_a, sign_b;
   logic [XLEN-1:0] mag_a, mag_b;

   assign idle      = (state_reg == S_IDLE);
   assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
   assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign launch    = idle && start && (op_mul || op_div);
   assign wr_hi     = idle && start && (op == OP_MTHI);
   assign wr_lo     = idle && start && (op == OP_MTLO);

   assign sign_a = op_signed && in_1[XLEN-1];
   assign sign_b = op_signed && in_2[XLEN-1];
   assign mag_a  = sign_a ? (~in_1 + 1'b1) : in_1;
   assign mag_b  = sign_b ? (~in_2 + 1'b1) : in_2;

   // Multiply step: acc = {partial product, remaining multiplier bits}
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_step;

   assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]}
                   + (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
   assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

   // Divide step: acc = {partial remainder, dividend bits shifting into quotient}
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_sub;
   logic [2*XLEN-1:0] div_step;

   assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
   assign div_ge    = (div_shift >= {1'b0, opnd_reg});
   // When div_ge holds the true difference is below the divisor, so XLEN bits suffice
   assign div_sub   = div_shift[XLEN-1:0] - opnd_reg;
   assign div_step  = {(div_ge ? div_sub : div_shift[XLEN-1:0]),
                       acc_reg[XLEN-2:0], div_ge};

   always_comb begin
      acc_next = acc_reg;
      case (state_reg)
         S_IDLE: begin
            if (launch) begin
               acc_next = op_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            end
         end
         S_RUN:   acc_next = is_div_reg ? div_step : mul_step;
         default: acc_next = acc_reg;
      endcase
   end

   // Sign correction and divide-by-zero result, committed during FIX
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot, rem;
   logic [XLEN-1:0]   fix_hi, fix_lo;

   assign prod_fix = neg_res_reg ? (~acc_reg + 1'b1) : acc_reg;
   assign quot     = acc_reg[XLEN-1:0];
   assign rem      = acc_reg[2*XLEN-1:XLEN];

   always_comb begin
      fix_hi = prod_fix[2*XLEN-1:XLEN];
      fix_lo = prod_fix[XLEN-1:0];
      if (is_div_reg) begin
         if (div0_reg) begin
            fix_hi = raw_a_reg;
            fix_lo = {XLEN{1'b1}};
         end else begin
            fix_hi = neg_rem_reg ? (~rem + 1'b1) : rem;
            fix_lo = neg_res_reg ? (~quot + 1'b1) : quot;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (launch) state_next = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (cnt_reg == 6'(ITER-1)) state_next = S_FIX;
         end
         S_FIX: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         cnt_reg      <= 6'd0;
         acc_reg      <= '0;
         opnd_reg     <= '0;
         raw_a_reg    <= '0;
         is_div_reg   <= 1'b0;
         neg_res_reg  <= 1'b0;
         neg_rem_reg  <= 1'b0;
         div0_reg     <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;

         if (launch) begin
            cnt_reg     <= 6'd0;
            opnd_reg    <= op_div ? mag_b : mag_a;
            raw_a_reg   <= in_1;
            is_div_reg  <= op_div;
            neg_res_reg <= sign_a ^ sign_b;
            neg_rem_reg <= sign_a;
            div0_reg    <= op_div && (in_2 == '0);
         end else if (state_reg == S_RUN) begin
            cnt_reg <= cnt_reg + 6'd1;
         end

         if (state_reg == S_FIX) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
         end else begin
            if (wr_hi) hi_reg <= in_1;
            if (wr_lo) lo_reg <= in_1;
         end

         // Reads return the pre-edge register value; a stalled read is simply retried
         rd_valid_reg <= rd_en && !busy;
         if (rd_en && !busy) begin
            rd_data_reg <= rd_sel ? hi_reg : lo_reg;
         end
      end
   end

   assign stall    = rd_en && busy;
   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign hi       = hi_reg;
   assign lo       = lo_reg;

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
- Multi-cycle iterative multiply/divide unit that owns the architectural HI/LO registers. It also provides the MFHI/MFLO read port back to the pipeline.
- The pipeline initiates MULT/MULTU/DIV/DIVU/MTHI/MTLO. This block responds with a busy/done handshake and stalls HI/LO reads until the result has committed.
- Sits beside the execute stage. It replaces the single-cycle combinational HI/LO path with a 32-iteration shift-add / restoring-divide datapath.

Parameters:
- XLEN, 32, operand and HI/LO width
- ITER, 32, iteration count; must equal XLEN

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  request strobe; sampled only in IDLE
- op  input  3  0 MTHI, 1 MTLO, 2 MULT, 3 MULTU, 4 DIV, 5 DIVU, 6-7 no-op
- in_1  input  XLEN  rs operand (dividend / multiplicand / MTxx data)
- in_2  input  XLEN  rt operand (divisor / multiplier)
- rd_en  input  1  MFHI/MFLO request
- rd_sel  input  1  0 LO, 1 HI
- rd_data  output  XLEN  registered read data
- rd_valid  output  1  rd_data valid, one-cycle pulse
- stall  output  1  combinational: rd_en & busy
- busy  output  1  iterative operation in flight
- done  output  1  one-cycle pulse when HI/LO commit an iterative result
- hi  output  XLEN  architectural HI
- lo  output  XLEN  architectural LO

Behaviour:
- Reset values: hi=0, lo=0, rd_data=0, rd_valid=0, busy=0, done=0, state=IDLE. Internal accumulators are cleared.
- Reset mid-operation aborts the operation. The next cycle shows hi=lo=0, busy=0, and no done pulse.
- States:
  - IDLE: on start with op 0/1, write hi or lo at the clock edge and stay in IDLE. busy and done stay 0.
  - IDLE: on start with op 2-5, latch operand magnitudes and sign flags, then go to RUN. busy=1 from the next cycle.
  - IDLE: on start with op 6/7, nothing happens.
  - RUN: one iteration per cycle with a 6-bit counter running 0..ITER-1. After iteration ITER-1, go to FIX.
  - FIX: apply sign correction, write hi/lo at the clock edge, and return to IDLE. done=1 during FIX; busy drops the cycle after FIX.
- Latency: start at cycle N → busy=1 for cycles N+1..N+33 → new hi/lo visible at N+34. This is the same for all op 2-5, including divide-by-zero.
- start while busy is ignored. The pipeline must hold the request.
- Multiply:
  - Unsigned 64-bit shift-add on magnitudes.
  - MULT negates the 64-bit product when the operand signs differ.
  - hi=prod[63:32], lo=prod[31:0].
- Divide:
  - Restoring division on magnitudes gives quotient Q and remainder R.
  - For DIV, lo=Q negated if the signs differ. hi=R with the sign of the dividend (truncating semantics, e.g. -7/2 → Q=-3, R=-1).
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero: lo=0xFFFFFFFF, hi=in_1 as latched, for both DIV and DIVU. No sign fix is applied.
- Read port:
  - rd_en with busy=0 in cycle N gives rd_valid=1 and rd_data equal to the selected register in cycle N+1.
  - The read returns the pre-edge value. A same-cycle MTHI/MTLO or start is not forwarded.
  - rd_en with busy=1 gives stall=1 and rd_valid=0. The pipeline holds rd_en and the read completes once busy=0.
  - A read issued in the FIX cycle stalls; it reads the new value on the following cycle.
- rd_data holds its last value when rd_valid=0.
- hi/lo outputs change only on a MTxx write, on FIX, or on reset.

Test Plan:
- MULT 0xFFFFFFFE × 3 → after 33 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV 0xFFFFFFF9 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 → lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5, same 33-cycle latency, done pulses.
- Start DIVU 100 / 7, then MFLO (rd_en=1, rd_sel=0) held from 5 cycles later → stall=1 until busy=0, then rd_valid=1 with rd_data=14 (0x0000000E). A second start pulsed while busy is ignored: hi=2 and no extra done pulse.
- MTHI 0x12345678, then MFHI next cycle → rd_valid with 0x12345678, busy never asserted. MTLO plus MFLO in the same cycle → old lo returned.
- Start MULT, assert reset at busy cycle 10 → next cycle hi=lo=0, busy=0, no done. A fresh MULTU 2×3 afterwards → lo=6, hi=0.
